// File: rtl/io_pkg.sv
// Shared defaults and types for the buffered keyboard/VGA I/O port.
package io_pkg;

  localparam int DATA_W_DEFAULT   = 8;
  localparam int IO_DEPTH_DEFAULT = 16;

  typedef logic [DATA_W_DEFAULT-1:0] char_t;

  // Occupancy counters need one extra bit so that "full" is representable.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with registered status flags.
// A push into a full FIFO is still accepted when a pop completes in the same cycle.
module sync_fifo
  import io_pkg::*;
#(
  parameter int W     = DATA_W_DEFAULT,
  parameter int DEPTH = IO_DEPTH_DEFAULT
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          pop_ok;
  logic          push_ok;

  // Pop on empty is ignored, which also makes push+pop on empty a plain push.
  always_comb begin
    pop_ok  = pop & ~empty_q;
    push_ok = push & (~full_q | pop_ok);
    drop    = push & ~push_ok;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_ok) wptr_d = wptr_q + PTR_ONE;
    if (pop_ok)  rptr_d = rptr_q + PTR_ONE;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CNT_FULL);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  // Storage is not reset; writes are blocked during reset so the head stays stable.
  always_ff @(posedge clock) begin
    if (reset && push_ok) mem_q[wptr_q] <= din;
  end

  assign dout  = mem_q[rptr_q];
  assign count = count_q;
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/io_buffered_port.sv
// Buffered keyboard-in / VGA-out glue: two FIFOs, interrupt enable,
// output-pending interrupt qualifier and sticky overflow flags.
module io_buffered_port
  import io_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEFAULT,
  parameter int IN_DEPTH  = IO_DEPTH_DEFAULT,
  parameter int OUT_DEPTH = IO_DEPTH_DEFAULT
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [DATA_W-1:0]          kbd_data,
  input  logic                       kbd_valid,
  output logic [DATA_W-1:0]          inpr_data,
  output logic                       fgi,
  input  logic                       inp_ack,
  input  logic [DATA_W-1:0]          outr_data,
  input  logic                       out_load,
  output logic                       fgo,
  output logic [DATA_W-1:0]          disp_data,
  output logic                       disp_valid,
  input  logic                       disp_ready,
  input  logic                       ien_set,
  input  logic                       ien_clr,
  output logic                       irq,
  output logic [$clog2(IN_DEPTH):0]  in_count,
  output logic [$clog2(OUT_DEPTH):0] out_count,
  output logic                       in_ovf,
  output logic                       out_ovf,
  input  logic                       ovf_clr
);

  localparam int OCW = count_width(OUT_DEPTH);
  localparam logic [OCW-1:0] OUT_ONE = OCW'(1);

  logic in_full_unused;
  logic in_empty, in_drop;
  logic out_full, out_empty, out_drop;
  logic out_hs, out_acc, out_drains;
  logic ien_q, ien_d;
  logic pend_q, pend_d;
  logic in_ovf_q, in_ovf_d;
  logic out_ovf_q, out_ovf_d;

  sync_fifo #(.W(DATA_W), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clock (clock),
    .reset (reset),
    .push  (kbd_valid),
    .pop   (inp_ack),
    .din   (kbd_data),
    .dout  (inpr_data),
    .count (in_count),
    .full  (in_full_unused),
    .empty (in_empty),
    .drop  (in_drop)
  );

  sync_fifo #(.W(DATA_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clock (clock),
    .reset (reset),
    .push  (out_load),
    .pop   (disp_ready),
    .din   (outr_data),
    .dout  (disp_data),
    .count (out_count),
    .full  (out_full),
    .empty (out_empty),
    .drop  (out_drop)
  );

  // The pending qualifier drops once the last queued character is handed to the display.
  always_comb begin
    out_hs     = disp_ready & ~out_empty;
    out_acc    = out_load & ~out_drop;
    out_drains = out_hs & ~out_acc & (out_count == OUT_ONE);
    ien_d      = ien_q;
    if (ien_clr)      ien_d = 1'b0;
    else if (ien_set) ien_d = 1'b1;
    pend_d = pend_q;
    if (out_acc)         pend_d = 1'b1;
    else if (out_drains) pend_d = 1'b0;
    in_ovf_d  = in_drop  | (in_ovf_q  & ~ovf_clr);
    out_ovf_d = out_drop | (out_ovf_q & ~ovf_clr);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      ien_q     <= 1'b0;
      pend_q    <= 1'b0;
      in_ovf_q  <= 1'b0;
      out_ovf_q <= 1'b0;
    end else begin
      ien_q     <= ien_d;
      pend_q    <= pend_d;
      in_ovf_q  <= in_ovf_d;
      out_ovf_q <= out_ovf_d;
    end
  end

  // Every flag below is a function of flops only, so no input reaches an output.
  assign fgi        = ~in_empty;
  assign fgo        = ~out_full;
  assign disp_valid = ~out_empty;
  assign in_ovf     = in_ovf_q;
  assign out_ovf    = out_ovf_q;
  assign irq        = ien_q & (fgi | (fgo & pend_q));

endmodule

// File: tb/tb_io_buffered_port.sv
// Randomised and directed bench for io_buffered_port against a queue-based model.
module tb_io_buffered_port;
  import io_pkg::*;

  localparam int DW  = 8;
  localparam int ID  = 16;
  localparam int OD  = 16;
  localparam int ICW = $clog2(ID) + 1;
  localparam int OCW = $clog2(OD) + 1;

  logic           clock, reset;
  logic [DW-1:0]  kbd_data, outr_data, inpr_data, disp_data;
  logic           kbd_valid, inp_ack, out_load, disp_ready;
  logic           fgi, fgo, disp_valid, irq, in_ovf, out_ovf;
  logic           ien_set, ien_clr, ovf_clr;
  logic [ICW-1:0] in_count;
  logic [OCW-1:0] out_count;

  io_buffered_port #(.DATA_W(DW), .IN_DEPTH(ID), .OUT_DEPTH(OD)) dut (
    .clock(clock), .reset(reset),
    .kbd_data(kbd_data), .kbd_valid(kbd_valid),
    .inpr_data(inpr_data), .fgi(fgi), .inp_ack(inp_ack),
    .outr_data(outr_data), .out_load(out_load), .fgo(fgo),
    .disp_data(disp_data), .disp_valid(disp_valid), .disp_ready(disp_ready),
    .ien_set(ien_set), .ien_clr(ien_clr), .irq(irq),
    .in_count(in_count), .out_count(out_count),
    .in_ovf(in_ovf), .out_ovf(out_ovf), .ovf_clr(ovf_clr)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int    total = 0;
  int    bad   = 0;
  char_t inQ[$];
  char_t outQ[$];
  bit    mIen, mPend, mInOvf, mOutOvf;

  task automatic applyStimulus(input bit kv, input logic [DW-1:0] kd, input bit ack,
                               input bit ol, input logic [DW-1:0] od, input bit dr,
                               input bit is, input bit ic, input bit oc);
    kbd_valid = kv; kbd_data = kd; inp_ack = ack;
    out_load = ol; outr_data = od; disp_ready = dr;
    ien_set = is; ien_clr = ic; ovf_clr = oc;
  endtask

  // Advance the model from the inputs about to be sampled, then clock the DUT.
  task automatic tick();
    bit inPop, inAcc, outPop, outAcc;
    if (!reset) begin
      inQ.delete(); outQ.delete();
      mIen = 0; mPend = 0; mInOvf = 0; mOutOvf = 0;
    end else begin
      inPop  = inp_ack && inQ.size() > 0;
      inAcc  = kbd_valid && (inQ.size() < ID || inPop);
      outPop = disp_ready && outQ.size() > 0;
      outAcc = out_load && (outQ.size() < OD || outPop);
      if (inPop)  void'(inQ.pop_front());
      if (inAcc)  inQ.push_back(kbd_data);
      if (outPop) void'(outQ.pop_front());
      if (outAcc) outQ.push_back(outr_data);
      if (kbd_valid && !inAcc)      mInOvf = 1;
      else if (ovf_clr)             mInOvf = 0;
      if (out_load && !outAcc)      mOutOvf = 1;
      else if (ovf_clr)             mOutOvf = 0;
      if (ien_clr)                  mIen = 0;
      else if (ien_set)             mIen = 1;
      if (outAcc)                   mPend = 1;
      else if (outQ.size() == 0)    mPend = 0;
    end
    @(posedge clock);
    #1;
  endtask

  function automatic bit expIrq();
    return mIen && (inQ.size() > 0 || (outQ.size() < OD && mPend));
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0);
    tick(); tick();
    reset = 1'b1;
    total += 8;
    if (fgi !== 1'b0)        begin bad++; $display("[TB] FAIL rst_fgi got=%b exp=0", fgi); end
    if (fgo !== 1'b1)        begin bad++; $display("[TB] FAIL rst_fgo got=%b exp=1", fgo); end
    if (disp_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_dv got=%b exp=0", disp_valid); end
    if (irq !== 1'b0)        begin bad++; $display("[TB] FAIL rst_irq got=%b exp=0", irq); end
    if (in_count !== '0)     begin bad++; $display("[TB] FAIL rst_incnt got=%0d exp=0", in_count); end
    if (out_count !== '0)    begin bad++; $display("[TB] FAIL rst_outcnt got=%0d exp=0", out_count); end
    if (in_ovf !== 1'b0)     begin bad++; $display("[TB] FAIL rst_inovf got=%b exp=0", in_ovf); end
    if (out_ovf !== 1'b0)    begin bad++; $display("[TB] FAIL rst_outovf got=%b exp=0", out_ovf); end
  endtask

  task automatic test_input_basic();
    logic [DW-1:0] keys [3];
    keys[0] = 8'h41; keys[1] = 8'h42; keys[2] = 8'h43;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, keys[i], 0, 0, 8'h00, 0, 0, 0, 0);
      tick();
    end
    applyStimulus(0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0);
    total += 3;
    if (fgi !== 1'b1)         begin bad++; $display("[TB] FAIL in3_fgi got=%b exp=1", fgi); end
    if (in_count !== 5'd3)    begin bad++; $display("[TB] FAIL in3_cnt got=%0d exp=3", in_count); end
    if (inpr_data !== 8'h41)  begin bad++; $display("[TB] FAIL in3_head got=%h exp=41", inpr_data); end
    tick();
    total++;
    if (inpr_data !== 8'h42)  begin bad++; $display("[TB] FAIL ack1_head got=%h exp=42", inpr_data); end
    tick();
    total++;
    if (inpr_data !== 8'h43)  begin bad++; $display("[TB] FAIL ack2_head got=%h exp=43", inpr_data); end
    tick();
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0);
    total += 2;
    if (fgi !== 1'b0)         begin bad++; $display("[TB] FAIL ack3_fgi got=%b exp=0", fgi); end
    if (in_count !== 5'd0)    begin bad++; $display("[TB] FAIL ack3_cnt got=%0d exp=0", in_count); end
  endtask

  task automatic test_input_overflow();
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1, 8'(8'h60 + i), 0, 0, 8'h00, 0, 0, 0, 0);
      tick();
    end
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 1);
    total += 3;
    if (in_count !== 5'd16)  begin bad++; $display("[TB] FAIL ovf_cnt got=%0d exp=16", in_count); end
    if (in_ovf !== 1'b1)     begin bad++; $display("[TB] FAIL ovf_set got=%b exp=1", in_ovf); end
    if (inpr_data !== 8'h60) begin bad++; $display("[TB] FAIL ovf_head got=%h exp=60", inpr_data); end
    tick();
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0);
    total += 2;
    if (in_ovf !== 1'b0)     begin bad++; $display("[TB] FAIL ovf_clr got=%b exp=0", in_ovf); end
    if (in_count !== 5'd16)  begin bad++; $display("[TB] FAIL ovf_clr_cnt got=%0d exp=16", in_count); end
  endtask

  task automatic test_full_push_pop();
    logic [DW-1:0] expHead;
    applyStimulus(1, 8'h5A, 1, 0, 8'h00, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0);
    total += 3;
    if (in_count !== 5'd16)  begin bad++; $display("[TB] FAIL fpp_cnt got=%0d exp=16", in_count); end
    if (in_ovf !== 1'b0)     begin bad++; $display("[TB] FAIL fpp_ovf got=%b exp=0", in_ovf); end
    if (inpr_data !== 8'h61) begin bad++; $display("[TB] FAIL fpp_head got=%h exp=61", inpr_data); end
    for (int i = 0; i < 16; i++) begin
      expHead = (i < 15) ? 8'(8'h61 + i) : 8'h5A;
      total++;
      if (inpr_data !== expHead) begin
        bad++; $display("[TB] FAIL drain_head idx=%0d got=%h exp=%h", i, inpr_data, expHead);
      end
      tick();
    end
    tick();
    total += 2;
    if (fgi !== 1'b0)        begin bad++; $display("[TB] FAIL ack_empty_fgi got=%b exp=0", fgi); end
    if (in_count !== 5'd0)   begin bad++; $display("[TB] FAIL ack_empty_cnt got=%0d exp=0", in_count); end
    applyStimulus(1, 8'h77, 1, 0, 8'h00, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0);
    total += 2;
    if (in_count !== 5'd1)   begin bad++; $display("[TB] FAIL epp_cnt got=%0d exp=1", in_count); end
    if (inpr_data !== 8'h77) begin bad++; $display("[TB] FAIL epp_head got=%h exp=77", inpr_data); end
    tick();
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0);
  endtask

  task automatic test_output_backpressure();
    logic [DW-1:0] expHead;
    applyStimulus(0, 8'h00, 0, 1, 8'h48, 0, 0, 0, 0); tick();
    applyStimulus(0, 8'h00, 0, 1, 8'h49, 0, 0, 0, 0); tick();
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      total += 2;
      if (disp_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_dv cyc=%0d got=%b exp=1", i, disp_valid); end
      if (disp_data !== 8'h48) begin bad++; $display("[TB] FAIL bp_data cyc=%0d got=%h exp=48", i, disp_data); end
      tick();
    end
    disp_ready = 1'b1;
    tick();
    total++;
    if (disp_data !== 8'h49) begin bad++; $display("[TB] FAIL hs1_data got=%h exp=49", disp_data); end
    tick();
    disp_ready = 1'b0;
    total += 3;
    if (disp_valid !== 1'b0) begin bad++; $display("[TB] FAIL hs2_dv got=%b exp=0", disp_valid); end
    if (fgo !== 1'b1)        begin bad++; $display("[TB] FAIL hs2_fgo got=%b exp=1", fgo); end
    if (out_count !== 5'd0)  begin bad++; $display("[TB] FAIL hs2_cnt got=%0d exp=0", out_count); end
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 8'h00, 0, 1, 8'(8'h80 + i), 0, 0, 0, 0);
      tick();
    end
    total += 2;
    if (fgo !== 1'b0)        begin bad++; $display("[TB] FAIL ofull_fgo got=%b exp=0", fgo); end
    if (out_count !== 5'd16) begin bad++; $display("[TB] FAIL ofull_cnt got=%0d exp=16", out_count); end
    applyStimulus(0, 8'h00, 0, 1, 8'hFF, 0, 0, 0, 0); tick();
    total++;
    if (out_ovf !== 1'b1)    begin bad++; $display("[TB] FAIL oovf_set got=%b exp=1", out_ovf); end
    applyStimulus(0, 8'h00, 0, 1, 8'hFE, 0, 0, 0, 1); tick();
    total++;
    if (out_ovf !== 1'b1)    begin bad++; $display("[TB] FAIL oovf_win got=%b exp=1", out_ovf); end
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 1); tick();
    total++;
    if (out_ovf !== 1'b0)    begin bad++; $display("[TB] FAIL oovf_clr got=%b exp=0", out_ovf); end
    applyStimulus(0, 8'h00, 0, 1, 8'hAA, 1, 0, 0, 0); tick();
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 1, 0, 0, 0);
    total += 3;
    if (out_count !== 5'd16) begin bad++; $display("[TB] FAIL ofpp_cnt got=%0d exp=16", out_count); end
    if (out_ovf !== 1'b0)    begin bad++; $display("[TB] FAIL ofpp_ovf got=%b exp=0", out_ovf); end
    if (disp_data !== 8'h81) begin bad++; $display("[TB] FAIL ofpp_head got=%h exp=81", disp_data); end
    for (int i = 0; i < 16; i++) begin
      expHead = (i < 15) ? 8'(8'h81 + i) : 8'hAA;
      total++;
      if (disp_data !== expHead) begin
        bad++; $display("[TB] FAIL odrain_head idx=%0d got=%h exp=%h", i, disp_data, expHead);
      end
      tick();
    end
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0);
    total++;
    if (disp_valid !== 1'b0) begin bad++; $display("[TB] FAIL odrain_dv got=%b exp=0", disp_valid); end
  endtask

  task automatic test_irq();
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0); tick();
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0);
    total++;
    if (irq !== 1'b0) begin bad++; $display("[TB] FAIL irq_idle got=%b exp=0", irq); end
    applyStimulus(1, 8'h11, 0, 0, 8'h00, 0, 0, 0, 0); tick();
    applyStimulus(0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0);
    total++;
    if (irq !== 1'b1) begin bad++; $display("[TB] FAIL irq_key got=%b exp=1", irq); end
    tick();
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 0, 1, 1, 0);
    total++;
    if (irq !== 1'b0) begin bad++; $display("[TB] FAIL irq_ack got=%b exp=0", irq); end
    tick();
    applyStimulus(1, 8'h22, 0, 0, 8'h00, 0, 0, 0, 0); tick();
    applyStimulus(0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0);
    total += 2;
    if (irq !== 1'b0) begin bad++; $display("[TB] FAIL irq_setclr got=%b exp=0", irq); end
    if (fgi !== 1'b1) begin bad++; $display("[TB] FAIL irq_setclr_fgi got=%b exp=1", fgi); end
    tick();
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0); tick();
    applyStimulus(0, 8'h00, 0, 1, 8'h33, 0, 0, 0, 0); tick();
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 1, 0, 0, 0);
    total++;
    if (irq !== 1'b1) begin bad++; $display("[TB] FAIL irq_out got=%b exp=1", irq); end
    tick();
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0);
    total += 2;
    if (irq !== 1'b0)        begin bad++; $display("[TB] FAIL irq_drain got=%b exp=0", irq); end
    if (disp_valid !== 1'b0) begin bad++; $display("[TB] FAIL irq_drain_dv got=%b exp=0", disp_valid); end
    tick();
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0);
  endtask

  task automatic test_reset_midburst();
    reset = 1'b0; tick(); reset = 1'b1;
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0); tick();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 8'(8'hC0 + i), 0, (i < 3), 8'(8'hD0 + i), 0, 0, 0, 0);
      tick();
    end
    total += 3;
    if (in_count !== 5'd5)  begin bad++; $display("[TB] FAIL mb_incnt got=%0d exp=5", in_count); end
    if (out_count !== 5'd3) begin bad++; $display("[TB] FAIL mb_outcnt got=%0d exp=3", out_count); end
    if (irq !== 1'b1)       begin bad++; $display("[TB] FAIL mb_irq got=%b exp=1", irq); end
    reset = 1'b0;
    applyStimulus(1, 8'hEE, 1, 1, 8'hEF, 1, 0, 0, 0);
    tick();
    reset = 1'b1;
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0);
    total += 6;
    if (in_count !== 5'd0)   begin bad++; $display("[TB] FAIL mbr_incnt got=%0d exp=0", in_count); end
    if (out_count !== 5'd0)  begin bad++; $display("[TB] FAIL mbr_outcnt got=%0d exp=0", out_count); end
    if (fgi !== 1'b0)        begin bad++; $display("[TB] FAIL mbr_fgi got=%b exp=0", fgi); end
    if (fgo !== 1'b1)        begin bad++; $display("[TB] FAIL mbr_fgo got=%b exp=1", fgo); end
    if (irq !== 1'b0)        begin bad++; $display("[TB] FAIL mbr_irq got=%b exp=0", irq); end
    if (disp_valid !== 1'b0) begin bad++; $display("[TB] FAIL mbr_dv got=%b exp=0", disp_valid); end
    applyStimulus(1, 8'h01, 0, 0, 8'h00, 0, 0, 0, 0); tick();
    applyStimulus(0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0);
    total++;
    if (irq !== 1'b0) begin bad++; $display("[TB] FAIL mbr_ien got=%b exp=0", irq); end
    tick();
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    int pushPct, popPct;
    for (int c = 0; c < 800; c++) begin
      pushPct = (c % 200 < 100) ? 75 : 25;
      popPct  = (c % 200 < 100) ? 20 : 70;
      applyStimulus($urandom_range(99) < pushPct, 8'($urandom), $urandom_range(99) < popPct,
                    $urandom_range(99) < pushPct, 8'($urandom), $urandom_range(99) < popPct,
                    $urandom_range(99) < 5, $urandom_range(99) < 3, $urandom_range(99) < 4);
      tick();
      total += 8;
      if (fgi !== (inQ.size() > 0))          begin bad++; $display("[TB] FAIL rnd_fgi cyc=%0d got=%b exp=%b", c, fgi, inQ.size() > 0); end
      if (fgo !== (outQ.size() < OD))        begin bad++; $display("[TB] FAIL rnd_fgo cyc=%0d got=%b exp=%b", c, fgo, outQ.size() < OD); end
      if (disp_valid !== (outQ.size() > 0))  begin bad++; $display("[TB] FAIL rnd_dv cyc=%0d got=%b exp=%b", c, disp_valid, outQ.size() > 0); end
      if (in_count !== ICW'(inQ.size()))     begin bad++; $display("[TB] FAIL rnd_incnt cyc=%0d got=%0d exp=%0d", c, in_count, inQ.size()); end
      if (out_count !== OCW'(outQ.size()))   begin bad++; $display("[TB] FAIL rnd_outcnt cyc=%0d got=%0d exp=%0d", c, out_count, outQ.size()); end
      if (in_ovf !== mInOvf)                 begin bad++; $display("[TB] FAIL rnd_inovf cyc=%0d got=%b exp=%b", c, in_ovf, mInOvf); end
      if (out_ovf !== mOutOvf)               begin bad++; $display("[TB] FAIL rnd_outovf cyc=%0d got=%b exp=%b", c, out_ovf, mOutOvf); end
      if (irq !== expIrq())                  begin bad++; $display("[TB] FAIL rnd_irq cyc=%0d got=%b exp=%b", c, irq, expIrq()); end
      if (inQ.size() > 0) begin
        total++;
        if (inpr_data !== inQ[0]) begin bad++; $display("[TB] FAIL rnd_inhead cyc=%0d got=%h exp=%h", c, inpr_data, inQ[0]); end
      end
      if (outQ.size() > 0) begin
        total++;
        if (disp_data !== outQ[0]) begin bad++; $display("[TB] FAIL rnd_outhead cyc=%0d got=%h exp=%h", c, disp_data, outQ[0]); end
      end
    end
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0);
  endtask

  initial begin
    $display("[TB] starting io_buffered_port bench");
    test_reset();
    test_input_basic();
    test_input_overflow();
    test_full_push_pop();
    test_output_backpressure();
    test_irq();
    test_reset_midburst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
